nn_param_mem: RTL and testbench
===============================

NN_PARAM_MEM -- requirements
Module: nn_param_mem

Interface
REQ-001 SHALL have parameter DATA_W, 16, Q5.10 signed weight/bias word width.
REQ-002 SHALL have parameter WT_DEPTH, 256, weight RAM entries (power of 2).
REQ-003 SHALL have parameter BIAS_DEPTH, 64, bias RAM entries (power of 2).
REQ-004 SHALL have parameter N_LAYERS, 8, layer descriptor table entries.
REQ-005 SHALL have parameter MAX_FANIN, 32, largest fan-in per neuron.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports cfg_we/cfg_layer/cfg_wt_base/cfg_bias_base/cfg_fanin, input, 1/clog2(N_LAYERS)/clog2(WT_DEPTH)/clog2(BIAS_DEPTH)/clog2(MAX_FANIN+1), layer descriptor write.
REQ-009 SHALL have ports ld_we/ld_sel/ld_addr/ld_data, input, 1/1/clog2(WT_DEPTH)/DATA_W, parameter load (ld_sel 0=weight, 1=bias).
REQ-010 SHALL have ports req_valid, req_layer, req_neuron, input, 1/clog2(N_LAYERS)/6, fetch request; req_ready, output, 1.
REQ-011 SHALL have ports out_valid, out_is_bias, out_last, output, 1 each; out_data, output, DATA_W; out_ready, input, 1.
REQ-012 SHALL have port err, output, 1, sticky flag for requests to unconfigured layers.

Function
REQ-013 SHALL accept a request when req_valid && req_ready; req_ready high only in IDLE.
REQ-014 SHALL use FSM IDLE -> BIAS -> STREAM -> IDLE; BIAS emits one beat, STREAM emits fanin beats.
REQ-015 SHALL compute weight address = (wt_base + neuron*fanin + k) mod WT_DEPTH, k = 0..fanin-1, ascending.
REQ-016 SHALL compute bias address = (bias_base + neuron) mod BIAS_DEPTH.
REQ-017 SHALL present first beat (bias) with out_valid 2 cycles after request acceptance (1 decode, 1 sync RAM read).
REQ-018 SHALL advance a beat only on out_valid && out_ready; out_data/flags SHALL hold stable while out_valid && !out_ready.
REQ-019 SHALL sustain one beat per cycle with out_ready held high (prefetch, skid register of depth 1).
REQ-020 SHALL assert out_last on final weight beat; if fanin==0 SHALL assert out_last on bias beat and skip STREAM.
REQ-021 SHALL set out_is_bias=1 only on bias beat.
REQ-022 SHALL, for layer with valid bit clear, return to IDLE without output beats and set err until reset.
REQ-023 SHALL write ld_data to selected RAM in the cycle ld_we is high, any state; simultaneous read of same address SHALL return old data.
REQ-024 SHALL apply cfg_we in any state; an in-flight request SHALL use the descriptor latched at acceptance.
REQ-025 SHALL keep neuron*fanin product at clog2(WT_DEPTH) bits, upper bits discarded (wrap).

Reset
REQ-026 SHALL, on rst_n low, force state IDLE, k=0, out_valid=0, out_last=0, out_is_bias=0, out_data=0, err=0, req_ready=1 after release, descriptor valid bits cleared.
REQ-027 SHALL abort any in-flight stream on reset with no further beats; RAM contents SHALL NOT be reset.

Structure
REQ-028 SHALL place DATA_W default, fsm state enum and layer descriptor struct (wt_base, bias_base, fanin, valid) in package nn_mem_pkg.
REQ-029 SHALL instantiate sub-module nn_param_ram (simple dual-port sync RAM, 1 write + 1 read port, read-before-write) twice: weights and biases.

Verification
REQ-030 SHALL test layer 1 {wt_base=0, bias_base=0, fanin=4}, neuron 2, out_ready=1 -> bias[2], then weights[8..11], out_last on weight[11], 5 consecutive cycles.
REQ-031 SHALL test backpressure: out_ready toggled 1,0,0,1 per cycle -> no beat lost or duplicated, data stable while stalled.
REQ-032 SHALL test fanin=0 layer -> single bias beat with out_is_bias=1, out_last=1.
REQ-033 SHALL test wt_base=250, fanin=8, neuron 0, WT_DEPTH=256 -> addresses 250..255,0,1.
REQ-034 SHALL test request to unconfigured layer 5 -> no out_valid, err=1, req_ready back high within 3 cycles.
REQ-035 SHALL test rst_n pulse mid-stream at beat 3 -> out_valid 0 immediately, IDLE, err 0, next request served correctly.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// nn_mem_pkg: shared widths, FSM state type and layer descriptor for the parameter memory
package nn_mem_pkg;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_WT_DEPTH   = 256;
  localparam int DEF_BIAS_DEPTH = 64;
  localparam int DEF_N_LAYERS   = 8;
  localparam int DEF_MAX_FANIN  = 32;
  localparam int NEURON_W       = 6;
  localparam int WT_AW          = $clog2(DEF_WT_DEPTH);
  localparam int BIAS_AW        = $clog2(DEF_BIAS_DEPTH);
  localparam int FANIN_W        = $clog2(DEF_MAX_FANIN + 1);
  localparam int LAYER_W        = $clog2(DEF_N_LAYERS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BIAS   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  typedef struct packed {
    logic [WT_AW-1:0]   wt_base;
    logic [BIAS_AW-1:0] bias_base;
    logic [FANIN_W-1:0] fanin;
    logic               valid;
  } layer_desc_t;
endpackage

// File: rtl/nn_param_mem_if.sv
// nn_param_mem_if: fetch request channel and parameter output stream
interface nn_param_mem_if import nn_mem_pkg::*; #(
  parameter int DW = DEF_DATA_W,
  parameter int LW = LAYER_W,
  parameter int NW = NEURON_W
);
  logic          req_valid;
  logic          req_ready;
  logic [LW-1:0] req_layer;
  logic [NW-1:0] req_neuron;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_bias;
  logic          out_last;
  logic [DW-1:0] out_data;

  modport master (
    output req_valid, req_layer, req_neuron, out_ready,
    input  req_ready, out_valid, out_is_bias, out_last, out_data
  );

  modport slave (
    input  req_valid, req_layer, req_neuron, out_ready,
    output req_ready, out_valid, out_is_bias, out_last, out_data
  );
endinterface

// File: rtl/nn_param_ram.sv
// nn_param_ram: simple dual-port synchronous RAM, read returns old data on same-address write
module nn_param_ram import nn_mem_pkg::*; #(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_WT_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // write and registered read share the edge; rdata holds when no read is issued
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/nn_param_mem.sv
// nn_param_mem: per-neuron bias + weight streamer backed by descriptor table and two sync RAMs
module nn_param_mem import nn_mem_pkg::*; #(
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int WT_DEPTH   = DEF_WT_DEPTH,
  parameter  int BIAS_DEPTH = DEF_BIAS_DEPTH,
  parameter  int N_LAYERS   = DEF_N_LAYERS,
  parameter  int MAX_FANIN  = DEF_MAX_FANIN,
  localparam int WA         = $clog2(WT_DEPTH),
  localparam int BA         = $clog2(BIAS_DEPTH),
  localparam int LW         = $clog2(N_LAYERS),
  localparam int FW         = $clog2(MAX_FANIN + 1),
  localparam int NW         = NEURON_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [LW-1:0]     cfg_layer,
  input  logic [WA-1:0]     cfg_wt_base,
  input  logic [BA-1:0]     cfg_bias_base,
  input  logic [FW-1:0]     cfg_fanin,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [WA-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  nn_param_mem_if.slave     bus,
  output logic              err
);
  state_t          state;
  logic            ph;
  layer_desc_t     desc_tab [N_LAYERS];
  layer_desc_t     desc_q;
  logic [NW-1:0]   neuron_q;
  logic [FW-1:0]   k;
  logic [WA-1:0]   wt_ptr;
  logic [BA-1:0]   bias_addr;
  logic [WA-1:0]   prod;
  logic            en;
  logic            issue_b;
  logic            issue_w;
  logic            last_w;
  logic [DATA_W-1:0] wt_q;
  logic [DATA_W-1:0] bias_q;

  // the RAM output registers act as the output stage, so a new read may only be issued once the current beat leaves
  assign en      = !bus.out_valid || bus.out_ready;
  assign issue_b = en && state == S_BIAS && ph;
  assign issue_w = en && state == S_STREAM;
  assign last_w  = k + FW'(1) == desc_q.fanin;
  assign prod    = WA'(neuron_q) * WA'(desc_q.fanin);

  assign bus.req_ready = state == S_IDLE;
  assign bus.out_data  = bus.out_valid ? (bus.out_is_bias ? bias_q : wt_q) : '0;

  // layer descriptor table; valid bits cleared by reset, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LAYERS; i++) desc_tab[i] <= '0;
    end else if (cfg_we) begin
      desc_tab[cfg_layer] <= '{wt_base: cfg_wt_base, bias_base: cfg_bias_base, fanin: cfg_fanin, valid: 1'b1};
    end
  end

  // request FSM: accept, decode addresses (ph=0), issue bias read (ph=1), then stream weights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ph        <= 1'b0;
      k         <= '0;
      desc_q    <= '0;
      neuron_q  <= '0;
      wt_ptr    <= '0;
      bias_addr <= '0;
      err       <= 1'b0;
    end else if (state == S_IDLE) begin
      if (bus.req_valid) begin
        state    <= S_BIAS;
        ph       <= 1'b0;
        k        <= '0;
        desc_q   <= desc_tab[bus.req_layer];
        neuron_q <= bus.req_neuron;
      end
    end else if (state == S_BIAS && !ph) begin
      if (!desc_q.valid) begin
        err   <= 1'b1;
        state <= S_IDLE;
      end else begin
        ph        <= 1'b1;
        bias_addr <= desc_q.bias_base + BA'(neuron_q);
        wt_ptr    <= desc_q.wt_base + prod;
      end
    end else if (issue_b) begin
      k     <= '0;
      state <= desc_q.fanin == '0 ? S_IDLE : S_STREAM;
    end else if (issue_w) begin
      k      <= k + FW'(1);
      wt_ptr <= wt_ptr + WA'(1);
      if (last_w) state <= S_IDLE;
    end
  end

  // beat flags track the read issued into the RAM output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_is_bias <= 1'b0;
      bus.out_last    <= 1'b0;
    end else if (en) begin
      bus.out_valid   <= issue_b || issue_w;
      bus.out_is_bias <= issue_b;
      bus.out_last    <= issue_b ? desc_q.fanin == '0 : issue_w && last_w;
    end
  end

  nn_param_ram #(.DATA_W(DATA_W), .DEPTH(WT_DEPTH)) u_wt_ram (
    .clk   (clk),
    .we    (ld_we && !ld_sel),
    .waddr (ld_addr),
    .wdata (ld_data),
    .re    (issue_w),
    .raddr (wt_ptr),
    .rdata (wt_q)
  );

  nn_param_ram #(.DATA_W(DATA_W), .DEPTH(BIAS_DEPTH)) u_bias_ram (
    .clk   (clk),
    .we    (ld_we && ld_sel),
    .waddr (ld_addr[BA-1:0]),
    .wdata (ld_data),
    .re    (issue_b),
    .raddr (bias_addr),
    .rdata (bias_q)
  );
endmodule

// File: tb/tb_nn_param_mem.sv
// tb_nn_param_mem: scoreboard bench for the parameter streamer
module tb_nn_param_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_layer = '0;
  logic [7:0] cfg_wt_base = '0;
  logic [5:0] cfg_bias_base = '0;
  logic [5:0] cfg_fanin = '0;
  logic ld_we = 1'b0;
  logic ld_sel = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic err;

  nn_param_mem_if bus ();

  nn_param_mem dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we        (cfg_we),
    .cfg_layer     (cfg_layer),
    .cfg_wt_base   (cfg_wt_base),
    .cfg_bias_base (cfg_bias_base),
    .cfg_fanin     (cfg_fanin),
    .ld_we         (ld_we),
    .ld_sel        (ld_sel),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .bus           (bus),
    .err           (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  logic [31:0] sb [$];
  logic [15:0] wm [256];
  logic [15:0] bm [64];
  bit dv [8];
  int dwb [8];
  int dbb [8];
  int dfi [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int a, input logic [15:0] d);
    ld_we = 1'b1;
    ld_sel = sel;
    ld_addr = 8'(a);
    ld_data = d;
    tick();
    ld_we = 1'b0;
    if (sel) bm[a] = d;
    else wm[a] = d;
  endtask

  task automatic cfg(input int l, input int wb, input int bb, input int fi);
    cfg_we = 1'b1;
    cfg_layer = 3'(l);
    cfg_wt_base = 8'(wb);
    cfg_bias_base = 6'(bb);
    cfg_fanin = 6'(fi);
    tick();
    cfg_we = 1'b0;
    dv[l] = 1'b1;
    dwb[l] = wb;
    dbb[l] = bb;
    dfi[l] = fi;
  endtask

  task automatic expect_beats(input int l, input int n);
    int a;
    if (!dv[l]) return;
    sb.push_back({14'b0, 1'b1, 1'(dfi[l] == 0), bm[(dbb[l] + n) % 64]});
    for (int j = 0; j < dfi[l]; j++) begin
      a = (dwb[l] + (n * dfi[l]) % 256 + j) % 256;
      sb.push_back({14'b0, 1'b0, 1'(j == dfi[l] - 1), wm[a]});
    end
  endtask

  task automatic request(input int l, input int n);
    int w = 0;
    expect_beats(l, n);
    bus.req_valid = 1'b1;
    bus.req_layer = 3'(l);
    bus.req_neuron = 6'(n);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("req_accept_timeout", 0, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) tick();
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_is_bias"}, bus.out_is_bias, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ready"}, bus.req_ready, 1);
  endtask

  // scoreboard pop on every transfer, plus stability check across stalled cycles
  bit pv = 1'b0;
  bit pr = 1'b0;
  logic [31:0] prev = '0;
  logic [31:0] cur;
  logic [31:0] exp_beat;
  always @(negedge clk) begin
    cur = {13'b0, bus.out_valid, bus.out_is_bias, bus.out_last, bus.out_data};
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) chk("hold", cur, prev);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("extra_beat", cur, 0);
        else begin
          exp_beat = sb.pop_front();
          chk("beat", {14'b0, bus.out_is_bias, bus.out_last, bus.out_data}, exp_beat);
        end
        beats++;
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      prev = cur;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int b0;
    bus.req_valid = 1'b0;
    bus.req_layer = '0;
    bus.req_neuron = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    idle_outputs("reset");
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 256; a++) load(1'b0, a, 16'h1000 + 16'(a * 97));
    for (int a = 0; a < 64; a++) load(1'b1, a, 16'hB000 ^ 16'(a * 13));
    cfg(1, 0, 0, 4);
    cfg(2, 10, 20, 0);
    cfg(3, 250, 0, 8);
    cfg(4, 100, 7, 8);
    cfg(6, 5, 60, 32);
    cfg(0, 40, 3, 6);

    // latency and back-to-back throughput
    request(1, 2);
    @(negedge clk);
    chk("lat_c1", bus.out_valid, 0);
    @(negedge clk);
    chk("lat_c2", bus.out_valid, 1'b0);
    @(negedge clk);
    chk("lat_c3", bus.out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst", bus.out_valid, 1);
    end
    @(negedge clk);
    chk("burst_end", bus.out_valid, 0);
    drain();

    // backpressure 1,0,0,1 with a descriptor rewrite while in flight
    request(0, 3);
    for (int i = 0; i < 24; i++) begin
      bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
      if (i == 2) begin
        cfg_we = 1'b1;
        cfg_layer = 3'd0;
        cfg_wt_base = 8'd200;
        cfg_bias_base = 6'd50;
        cfg_fanin = 6'd2;
        dwb[0] = 200;
        dbb[0] = 50;
        dfi[0] = 2;
      end
      if (i == 3) cfg_we = 1'b0;
      tick();
    end
    bus.out_ready = 1'b1;
    drain();

    request(2, 5);
    drain();
    request(3, 0);
    drain();
    request(6, 20);
    drain();

    // unconfigured layer
    request(5, 1);
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("err_ready_lat", 32'(n <= 3), 1);
    chk("err_flag", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
    chk("err_no_beat", bus.out_valid, 0);

    // reset in the middle of a stream
    request(4, 1);
    b0 = beats;
    n = 0;
    while (beats < b0 + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_beat3", 32'(beats >= b0 + 3), 1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    idle_outputs("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int l = 0; l < 8; l++) dv[l] = 1'b0;
    tick();
    idle_outputs("post_rst");
    cfg(4, 100, 7, 8);
    request(4, 1);
    drain();
    chk("post_rst_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
